// File: rtl/riot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riot_pkg
// Purpose  : Shared constants and types for the RIOT core: I/O register
//            offsets, address-bit positions of the timer/edge register
//            decode, flag bit positions and the timer prescale encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riot_pkg;

    // I/O register offsets (A[1:0] when rs=1 and A[2]=0)
    localparam logic [1:0] c_OFF_PA_DATA = 2'd0;
    localparam logic [1:0] c_OFF_DDRA    = 2'd1;
    localparam logic [1:0] c_OFF_PB_DATA = 2'd2;
    localparam logic [1:0] c_OFF_DDRB    = 2'd3;

    // Address bit positions used by the timer / edge-control decode
    localparam int c_A_EDGE_POL  = 0;  // edge-control write: 1 = rising
    localparam int c_A_FLAG_SEL  = 0;  // read: 1 = flag register, 0 = counter
    localparam int c_A_EDGE_IE   = 1;  // edge-control write: edge IE
    localparam int c_A_TIMER_SEL = 2;  // 1 = timer/edge block, 0 = ports
    localparam int c_A_TIMER_IE  = 3;  // timer IE on timer write/read
    localparam int c_A_TIMER_WR  = 4;  // write: 1 = timer load, 0 = edge ctrl
    localparam int c_A_TIMER_HI  = 5;  // high counter byte (wide timers only)

    // Flag register bit positions
    localparam int c_FLAG_TIMER_BIT = 7;
    localparam int c_FLAG_EDGE_BIT  = 6;

    typedef enum logic [1:0] {
        P1    = 2'd0,
        P8    = 2'd1,
        P64   = 2'd2,
        P1024 = 2'd3
    } prescale_e;

    // log2 of the prescale period for each encoding
    localparam logic [3:0] c_PRESCALE_SHIFT [4] = '{4'd0, 4'd3, 4'd6, 4'd10};

    function automatic logic [3:0] prescale_shift(input prescale_e p);
        case (p)
            P1:      return c_PRESCALE_SHIFT[0];
            P8:      return c_PRESCALE_SHIFT[1];
            P64:     return c_PRESCALE_SHIFT[2];
            P1024:   return c_PRESCALE_SHIFT[3];
            default: return c_PRESCALE_SHIFT[0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riot_timer.sv
`default_nettype none
// ============================================================================
// Module   : riot_timer
// Purpose  : Interval timer: down-counter, prescaler, underflow flag and IE.
//   clk, rst        : clock, asynchronous active-high reset
//   i_load          : load counter with i_load_val, prescale i_presc, IE i_ie
//   i_rd            : counter read side effects (IE <= i_ie, clear flag)
//   o_count         : current counter value
//   o_flag, o_ie    : current flag / IE
//   o_flag_nxt/_ie_nxt : values they take at the next clock edge
// Revision : 1.0 - initial release
// ============================================================================
module riot_timer
    import riot_pkg::*;
#(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_rd,
    input  logic               i_ie,
    input  prescale_e          i_presc,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_flag,
    output logic               o_ie,
    output logic               o_flag_nxt,
    output logic               o_ie_nxt
);

    logic [TIMER_W-1:0] r_cnt;
    logic [TIMER_W-1:0] w_cnt_d;
    logic [9:0]         r_pre;
    logic [9:0]         w_pre_d;
    logic [3:0]         r_shift;
    logic [3:0]         w_shift_d;
    logic               r_run;
    logic               w_run_d;
    logic               r_flag;
    logic               w_flag_d;
    logic               r_ie;
    logic               w_ie_d;
    logic [10:0]        w_period;
    logic [10:0]        w_period_m1;
    logic               w_tick;
    logic               w_underflow;

    assign w_period    = 11'd1 << r_shift;
    assign w_period_m1 = w_period - 11'd1;
    // The prescaler counts 0..period-1; the decrement happens on the edge
    // where it has reached period-1, i.e. one full period after a load.
    assign w_tick      = r_run && ({1'b0, r_pre} == w_period_m1);
    assign w_underflow = w_tick && (r_cnt == '0);

    always_comb begin
        w_cnt_d   = r_cnt;
        w_pre_d   = r_pre;
        w_shift_d = r_shift;
        w_run_d   = r_run;
        w_flag_d  = r_flag;
        w_ie_d    = r_ie;

        if (r_run) begin
            w_pre_d = w_tick ? 10'd0 : r_pre + 10'd1;
        end
        if (w_tick) begin
            w_cnt_d = r_cnt - TIMER_W'(1);
        end
        if (w_underflow) begin
            w_shift_d = prescale_shift(P1);
        end

        // A read clears the flag, but an underflow on the same edge wins.
        if (i_rd) begin
            w_ie_d   = i_ie;
            w_flag_d = 1'b0;
        end
        if (w_underflow) begin
            w_flag_d = 1'b1;
        end

        // A load overrides everything, including a coincident underflow.
        if (i_load) begin
            w_cnt_d   = i_load_val;
            w_pre_d   = 10'd0;
            w_shift_d = prescale_shift(i_presc);
            w_run_d   = 1'b1;
            w_ie_d    = i_ie;
            w_flag_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pre   <= 10'd0;
            r_shift <= prescale_shift(P1);
            r_run   <= 1'b0;
            r_flag  <= 1'b0;
            r_ie    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_pre   <= w_pre_d;
            r_shift <= w_shift_d;
            r_run   <= w_run_d;
            r_flag  <= w_flag_d;
            r_ie    <= w_ie_d;
        end
    end

    assign o_count    = r_cnt;
    assign o_flag     = r_flag;
    assign o_ie       = r_ie;
    assign o_flag_nxt = w_flag_d;
    assign o_ie_nxt   = w_ie_d;

endmodule
`default_nettype wire

// File: rtl/riot_core.sv
`default_nettype none
// ============================================================================
// Module   : riot_core
// Purpose  : RAM / I/O / timer combination chip. Byte RAM, two I/O ports
//            with direction registers, edge detector on PA[PORT_W-1] and an
//            interval timer, all accessed through one register bus.
//   phi2, rst          : clock, asynchronous active-high reset
//   cs, rs, we_n, A, DI: bus access (rs=0 RAM, rs=1 I/O/timer)
//   DO, OE             : registered read data, OE pulses one cycle per read
//   PAI/PBI            : port pin inputs (synchronised internally)
//   PAO/PBO, DDRA/DDRB : port output and direction registers (1 = output)
//   IRQ, IRQ_EN        : interrupt request, OR of enabled source IEs
// Revision : 1.0 - initial release
// ============================================================================
module riot_core
    import riot_pkg::*;
#(
    parameter int RAM_DEPTH = 128,
    parameter int PORT_W    = 8,
    parameter int TIMER_W   = 8
) (
    input  logic                         phi2,
    input  logic                         rst,
    input  logic                         cs,
    input  logic                         rs,
    input  logic                         we_n,
    input  logic [$clog2(RAM_DEPTH)-1:0] A,
    input  logic [7:0]                   DI,
    output logic [7:0]                   DO,
    output logic                         OE,
    input  logic [PORT_W-1:0]            PAI,
    input  logic [PORT_W-1:0]            PBI,
    output logic [PORT_W-1:0]            PAO,
    output logic [PORT_W-1:0]            PBO,
    output logic [PORT_W-1:0]            DDRA,
    output logic [PORT_W-1:0]            DDRB,
    output logic                         IRQ,
    output logic                         IRQ_EN
);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_rd;
    logic w_wr;
    logic w_ram_wr;
    logic w_port_wr;
    logic w_tsel;
    logic w_tmr_wr_any;
    logic w_tmr_lo_sel;
    logic w_tmr_load;
    logic w_tmr_rd;
    logic w_flag_rd;
    logic w_edge_ctl_wr;

    assign w_rd          = cs & we_n;
    assign w_wr          = cs & ~we_n;
    assign w_ram_wr      = w_wr & ~rs;
    assign w_tsel        = rs & A[c_A_TIMER_SEL];
    assign w_port_wr     = w_wr & rs & ~A[c_A_TIMER_SEL];
    assign w_tmr_wr_any  = w_wr & w_tsel & A[c_A_TIMER_WR];
    assign w_edge_ctl_wr = w_wr & w_tsel & ~A[c_A_TIMER_WR];
    assign w_tmr_load    = w_tmr_wr_any & w_tmr_lo_sel;
    assign w_tmr_rd      = w_rd & w_tsel & ~A[c_A_FLAG_SEL] & w_tmr_lo_sel;
    assign w_flag_rd     = w_rd & w_tsel & A[c_A_FLAG_SEL];

    // ------------------------------------------------------------------
    // RAM (no reset: contents are undefined after reset)
    // ------------------------------------------------------------------
    logic [7:0] r_mem [RAM_DEPTH];

    always_ff @(posedge phi2) begin
        if (w_ram_wr) begin
            r_mem[A] <= DI;
        end
    end

    // ------------------------------------------------------------------
    // Ports, synchronisers and edge detector
    // ------------------------------------------------------------------
    logic [PORT_W-1:0] r_pao;
    logic [PORT_W-1:0] r_pbo;
    logic [PORT_W-1:0] r_ddra;
    logic [PORT_W-1:0] r_ddrb;
    logic [PORT_W-1:0] r_pa_s1;
    logic [PORT_W-1:0] r_pa_s2;
    logic [PORT_W-1:0] r_pb_s1;
    logic [PORT_W-1:0] r_pb_s2;
    logic              r_edge_prev;
    logic              r_edge_pol;
    logic              r_edge_ie;
    logic              r_edge_flag;
    logic              w_edge_evt;
    logic              w_edge_flag_d;
    logic              w_edge_ie_d;
    logic [PORT_W-1:0] w_pa_rd;
    logic [PORT_W-1:0] w_pb_rd;

    assign w_pa_rd = (r_ddra & r_pao) | (~r_ddra & r_pa_s2);
    assign w_pb_rd = (r_ddrb & r_pbo) | (~r_ddrb & r_pb_s2);

    // The edge pin is watched after synchronisation, regardless of DDRA.
    assign w_edge_evt = r_edge_pol ? ( r_pa_s2[PORT_W-1] & ~r_edge_prev)
                                   : (~r_pa_s2[PORT_W-1] &  r_edge_prev);

    // A new event on the same edge as a flag read keeps the flag set.
    assign w_edge_flag_d = w_edge_evt | (r_edge_flag & ~w_flag_rd);
    assign w_edge_ie_d   = w_edge_ctl_wr ? A[c_A_EDGE_IE] : r_edge_ie;

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            r_pao       <= '0;
            r_pbo       <= '0;
            r_ddra      <= '0;
            r_ddrb      <= '0;
            r_pa_s1     <= '0;
            r_pa_s2     <= '0;
            r_pb_s1     <= '0;
            r_pb_s2     <= '0;
            r_edge_prev <= 1'b0;
            r_edge_pol  <= 1'b0;
            r_edge_ie   <= 1'b0;
            r_edge_flag <= 1'b0;
        end else begin
            r_pa_s1     <= PAI;
            r_pa_s2     <= r_pa_s1;
            r_pb_s1     <= PBI;
            r_pb_s2     <= r_pb_s1;
            r_edge_prev <= r_pa_s2[PORT_W-1];
            r_edge_flag <= w_edge_flag_d;
            r_edge_ie   <= w_edge_ie_d;
            if (w_edge_ctl_wr) begin
                r_edge_pol <= A[c_A_EDGE_POL];
            end
            if (w_port_wr) begin
                case (A[1:0])
                    c_OFF_PA_DATA: r_pao  <= DI[PORT_W-1:0];
                    c_OFF_DDRA:    r_ddra <= DI[PORT_W-1:0];
                    c_OFF_PB_DATA: r_pbo  <= DI[PORT_W-1:0];
                    c_OFF_DDRB:    r_ddrb <= DI[PORT_W-1:0];
                    default:       r_pao  <= r_pao;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Interval timer
    // ------------------------------------------------------------------
    logic [TIMER_W-1:0] w_tmr_load_val;
    logic [TIMER_W-1:0] w_tmr_count;
    logic [7:0]         w_tmr_rd_byte;
    logic               w_tmr_flag;
    logic               w_tmr_ie;
    logic               w_tmr_flag_nxt;
    logic               w_tmr_ie_nxt;

    generate
        if (TIMER_W == 8) begin : g_timer_narrow
            assign w_tmr_load_val = DI;
            assign w_tmr_lo_sel   = 1'b1;
            assign w_tmr_rd_byte  = w_tmr_count[7:0];
        end else begin : g_timer_wide
            // High byte is staged by an A[5]=1 write and applied when the
            // low byte is written, which is what loads and starts the timer.
            logic [TIMER_W-9:0] r_tmr_hi;

            always_ff @(posedge phi2 or posedge rst) begin
                if (rst) begin
                    r_tmr_hi <= '0;
                end else if (w_tmr_wr_any && A[c_A_TIMER_HI]) begin
                    r_tmr_hi <= DI[TIMER_W-9:0];
                end
            end

            assign w_tmr_load_val = {r_tmr_hi, DI};
            assign w_tmr_lo_sel   = ~A[c_A_TIMER_HI];
            assign w_tmr_rd_byte  = A[c_A_TIMER_HI] ? 8'(w_tmr_count[TIMER_W-1:8])
                                                    : w_tmr_count[7:0];
        end
    endgenerate

    riot_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (phi2),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_rd       (w_tmr_rd),
        .i_ie       (A[c_A_TIMER_IE]),
        .i_presc    (prescale_e'(A[1:0])),
        .i_load_val (w_tmr_load_val),
        .o_count    (w_tmr_count),
        .o_flag     (w_tmr_flag),
        .o_ie       (w_tmr_ie),
        .o_flag_nxt (w_tmr_flag_nxt),
        .o_ie_nxt   (w_tmr_ie_nxt)
    );

    // ------------------------------------------------------------------
    // Read data mux, DO/OE and IRQ registers
    // ------------------------------------------------------------------
    logic [7:0] w_rdata;
    logic [7:0] r_do;
    logic       r_oe;
    logic       r_irq;

    always_comb begin
        w_rdata = r_mem[A];
        if (rs) begin
            w_rdata = 8'h00;
            if (!A[c_A_TIMER_SEL]) begin
                case (A[1:0])
                    c_OFF_PA_DATA: w_rdata = 8'(w_pa_rd);
                    c_OFF_DDRA:    w_rdata = 8'(r_ddra);
                    c_OFF_PB_DATA: w_rdata = 8'(w_pb_rd);
                    c_OFF_DDRB:    w_rdata = 8'(r_ddrb);
                    default:       w_rdata = 8'h00;
                endcase
            end else if (A[c_A_FLAG_SEL]) begin
                w_rdata[c_FLAG_TIMER_BIT] = w_tmr_flag;
                w_rdata[c_FLAG_EDGE_BIT]  = r_edge_flag;
            end else begin
                w_rdata = w_tmr_rd_byte;
            end
        end
    end

    // IRQ is registered from the next-state flags/IEs so that it tracks
    // the flag registers without an extra cycle of lag.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            r_do  <= 8'h00;
            r_oe  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_oe  <= w_rd;
            r_irq <= (w_tmr_flag_nxt & w_tmr_ie_nxt) | (w_edge_flag_d & w_edge_ie_d);
            if (w_rd) begin
                r_do <= w_rdata;
            end
        end
    end

    assign DO     = r_do;
    assign OE     = r_oe;
    assign IRQ    = r_irq;
    assign IRQ_EN = w_tmr_ie | r_edge_ie;
    assign PAO    = r_pao;
    assign PBO    = r_pbo;
    assign DDRA   = r_ddra;
    assign DDRB   = r_ddrb;

endmodule
`default_nettype wire

// File: tb/tb_riot_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_riot_core
// Purpose  : Self-checking bench for riot_core (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riot_core;

    logic       phi2 = 1'b0;
    logic       rst  = 1'b1;
    logic       cs   = 1'b0;
    logic       rs   = 1'b0;
    logic       we_n = 1'b1;
    logic [6:0] A    = 7'h00;
    logic [7:0] DI   = 8'h00;
    logic [7:0] PAI  = 8'h00;
    logic [7:0] PBI  = 8'h00;
    logic [7:0] DO;
    logic       OE;
    logic [7:0] PAO, PBO, DDRA, DDRB;
    logic       IRQ, IRQ_EN;

    riot_core #(.RAM_DEPTH(128), .PORT_W(8), .TIMER_W(8)) dut (
        .phi2(phi2), .rst(rst), .cs(cs), .rs(rs), .we_n(we_n), .A(A), .DI(DI),
        .DO(DO), .OE(OE), .PAI(PAI), .PBI(PBI), .PAO(PAO), .PBO(PBO),
        .DDRA(DDRA), .DDRB(DDRB), .IRQ(IRQ), .IRQ_EN(IRQ_EN)
    );

    always #5 phi2 = ~phi2;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // Timer reference: last load edge, loaded value, prescale period
    int t_load = 0;
    int t_v    = 0;
    int t_p    = 1;

    bit [7:0] mem_m [128];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge phi2);
        #1;
        ncyc++;
    endtask

    task automatic acc_write(input logic r, input logic [6:0] a, input logic [7:0] d);
        cs = 1'b1; rs = r; we_n = 1'b0; A = a; DI = d;
        tick();
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic acc_read(input logic r, input logic [6:0] a,
                            output logic [7:0] d, output logic oe);
        cs = 1'b1; rs = r; we_n = 1'b1; A = a;
        tick();
        cs = 1'b0;
        d  = DO;
        oe = OE;
    endtask

    // Counter value after the j-th edge following the load edge.
    function automatic int model_cnt(input int j);
        int n;
        n = j / t_p;
        if (n <= t_v) return t_v - n;
        return (255 - (j - (t_v + 1) * t_p)) & 255;
    endfunction

    task automatic tmr_load(input int v, input int ps, input bit ie);
        logic [6:0] a;
        a = {2'b00, 1'b1, ie, 1'b1, ps[1:0]};
        acc_write(1'b1, a, v[7:0]);
        t_load = ncyc;
        t_v    = v;
        case (ps)
            0: t_p = 1;
            1: t_p = 8;
            2: t_p = 64;
            default: t_p = 1024;
        endcase
    endtask

    task automatic tmr_read_check(input string tag, input bit ie);
        logic [7:0] d;
        logic       oe;
        int         e;
        acc_read(1'b1, {3'b000, ie, 3'b100}, d, oe);
        e = model_cnt(ncyc - t_load - 1);
        check(tag, 16'(d), e[15:0]);
        check({tag, "_oe"}, 16'(oe), 16'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       oe;
        int         v, ps, gap, tu;
        bit         ie;
        logic [7:0] ra, rb, pa, pb, ia, ib;
        logic [6:0] addr [8];

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_do_oe_irq", {5'b0, DO, OE, IRQ, IRQ_EN}, 16'h0000);
        check("rst_ports", {PAO, PBO}, 16'h0000);
        check("rst_ddr", {DDRA, DDRB}, 16'h0000);
        rst = 1'b0;
        tick();

        // ---------------- RAM ----------------
        acc_write(1'b0, 7'h10, 8'h55);
        acc_write(1'b0, 7'h7F, 8'hAA);
        acc_read(1'b0, 7'h10, d, oe);
        check("ram_10", 16'(d), 16'h55);
        check("ram_10_oe", 16'(oe), 16'd1);
        acc_read(1'b0, 7'h7F, d, oe);
        check("ram_7f", 16'(d), 16'hAA);
        tick();
        check("ram_oe_pulse", {7'b0, OE, DO}, 16'h00AA);
        for (int i = 0; i < 8; i++) begin
            addr[i] = 7'($urandom_range(0, 127));
            d = 8'($urandom);
            mem_m[addr[i]] = d;
            acc_write(1'b0, addr[i], d);
        end
        for (int i = 7; i >= 0; i--) begin
            acc_read(1'b0, addr[i], d, oe);
            check("ram_rand", {7'b0, oe, d}, {8'h01, mem_m[addr[i]]});
        end

        // ---------------- timer: prescale 8, load 3 ----------------
        tmr_load(3, 1, 1'b1);
        check("tmr_irq_en", 16'(IRQ_EN), 16'd1);
        tmr_read_check("tmr_rd3", 1'b1);
        while (ncyc < t_load + 8) tick();
        tmr_read_check("tmr_rd2", 1'b1);
        while (ncyc < t_load + 16) tick();
        tmr_read_check("tmr_rd1", 1'b1);
        while (ncyc < t_load + 24) tick();
        tmr_read_check("tmr_rd0", 1'b1);
        while (ncyc < t_load + 31) tick();
        check("tmr_pre_uf_irq", 16'(IRQ), 16'd0);
        tick();
        check("tmr_uf_irq", 16'(IRQ), 16'd1);
        tmr_read_check("tmr_rd_ff", 1'b1);
        check("tmr_rd_clr_irq", 16'(IRQ), 16'd0);
        tick();
        tick();
        tmr_read_check("tmr_rd_fast", 1'b1);

        // underflow on the same edge as a counter read: flag stays set
        tmr_load(1, 0, 1'b1);
        tmr_read_check("tmr_b_rd1", 1'b1);
        tmr_read_check("tmr_b_rd0", 1'b1);
        check("tmr_rd_uf_irq", 16'(IRQ), 16'd1);
        acc_read(1'b1, 7'h05, d, oe);
        check("tmr_flag_rd", 16'(d), 16'h80);
        check("tmr_flag_rd_keep", 16'(IRQ), 16'd1);

        // load on the same edge as an underflow: load wins
        tmr_load(0, 0, 1'b1);
        check("tmr_ld_clr_irq", 16'(IRQ), 16'd0);
        tmr_load(5, 0, 1'b1);
        check("tmr_ld_uf_irq", 16'(IRQ), 16'd0);
        tmr_read_check("tmr_ld_uf_val", 1'b1);

        // randomized timer runs
        for (int it = 0; it < 4; it++) begin
            ps = $urandom_range(0, 3);
            v  = (ps == 3) ? $urandom_range(0, 1) : $urandom_range(0, 12);
            ie = 1'($urandom_range(0, 1));
            tmr_load(v, ps, ie);
            tu = t_load + (v + 1) * t_p;
            for (int r = 0; r < 3; r++) begin
                gap = $urandom_range(0, t_p);
                if (ncyc + gap + 1 < tu) begin
                    repeat (gap) tick();
                    tmr_read_check("tmr_rand_rd", ie);
                end
            end
            while (ncyc < tu - 1) tick();
            check("tmr_rand_pre_irq", 16'(IRQ), 16'd0);
            tick();
            check("tmr_rand_irq", 16'(IRQ), 16'(ie));
            acc_read(1'b1, 7'h05, d, oe);
            check("tmr_rand_flag", 16'(d), 16'h80);
            tmr_read_check("tmr_rand_after", ie);
            check("tmr_rand_clr", 16'(IRQ), 16'd0);
        end

        // park the timer far from underflow with IE off
        tmr_load(255, 3, 1'b0);
        check("tmr_park_irq_en", 16'(IRQ_EN), 16'd0);

        // ---------------- ports ----------------
        PAI = 8'h0C;
        acc_write(1'b1, 7'h01, 8'hF0);
        acc_write(1'b1, 7'h00, 8'hA5);
        repeat (3) tick();
        acc_read(1'b1, 7'h00, d, oe);
        check("pa_mix", 16'(d), 16'hAC);
        check("pa_regs", {PAO, DDRA}, 16'hA5F0);
        for (int it = 0; it < 5; it++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            pa = 8'($urandom); pb = 8'($urandom);
            ia = 8'($urandom); ib = 8'($urandom);
            PAI = ia; PBI = ib;
            acc_write(1'b1, 7'h01, ra);
            acc_write(1'b1, 7'h00, pa);
            acc_write(1'b1, 7'h03, rb);
            acc_write(1'b1, 7'h02, pb);
            acc_read(1'b1, 7'h00, d, oe);
            check("pa_rand", 16'(d), 16'((ra & pa) | (~ra & ia)));
            acc_read(1'b1, 7'h02, d, oe);
            check("pb_rand", 16'(d), 16'((rb & pb) | (~rb & ib)));
            acc_read(1'b1, 7'h03, d, oe);
            check("ddrb_rd", 16'(d), 16'(rb));
            check("pb_regs", {PBO, DDRB}, {pb, rb});
        end

        // ---------------- edge detector ----------------
        PAI = 8'h00;
        repeat (3) tick();
        acc_write(1'b1, 7'h07, 8'h00);      // rising, IE=1
        acc_read(1'b1, 7'h05, d, oe);       // discard any stale edge flag
        check("edge_idle_irq", {IRQ, IRQ_EN}, 16'h0001);
        PAI = 8'h80;
        tick();
        tick();
        check("edge_sync_irq", 16'(IRQ), 16'd0);
        tick();
        check("edge_rise_irq", 16'(IRQ), 16'd1);
        acc_read(1'b1, 7'h05, d, oe);
        check("edge_flag_rd", 16'(d), 16'h40);
        check("edge_flag_clr", 16'(IRQ), 16'd0);

        acc_write(1'b1, 7'h06, 8'h00);      // falling, IE=1
        PAI = 8'h00;
        tick();
        tick();
        acc_read(1'b1, 7'h05, d, oe);       // read on the event edge
        check("edge_rd_same", {7'b0, IRQ, d}, 16'h0100);
        acc_read(1'b1, 7'h05, d, oe);
        check("edge_rd_after", {7'b0, IRQ, d}, 16'h0040);

        // ---------------- reset mid-run ----------------
        tmr_load(2, 0, 1'b1);
        for (int i = 0; i < 10 && !IRQ; i++) tick();
        check("rstrun_irq", 16'(IRQ), 16'd1);
        cs = 1'b1; rs = 1'b0; we_n = 1'b1; A = 7'h10;
        tick();
        cs = 1'b0;
        check("rstrun_oe", 16'(OE), 16'd1);
        #1 rst = 1'b1;
        #1;
        check("rstrun_out", {5'b0, DO, OE, IRQ, IRQ_EN}, 16'h0000);
        check("rstrun_ports", {PAO | PBO, DDRA | DDRB}, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        acc_read(1'b1, 7'h04, d, oe);
        check("rstrun_halt0", {7'b0, oe, d}, 16'h0100);
        repeat (5) tick();
        acc_read(1'b1, 7'h04, d, oe);
        check("rstrun_halt1", {7'b0, oe, d}, 16'h0100);
        check("rstrun_irq_lo", {IRQ, IRQ_EN}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
